// File: rtl/zwait_mc.sv
// Multi-source Z80 wait generator: edge-detected, queued CPU wait sources plus a
// DMA wait-port channel, with a programmable watchdog that releases stuck waits.
module zwait_mc #(
  parameter int NSRC = 4,
  parameter int DEVW = 2,
  parameter int TMOW = 16
) (
  input  logic            fclk,
  input  logic            rst,
  input  logic [NSRC-1:0] wait_start,
  input  logic            wait_end,
  input  logic            wr_n,
  input  logic            dma_wtp_req,
  input  logic [DEVW-1:0] dmawpdev,
  input  logic [TMOW-1:0] tmo_limit,
  input  logic            tmo_clr,
  output logic            wait_n,
  output logic            wait_oe,
  output logic [NSRC-1:0] wait_status,
  output logic            wait_status_wrn,
  output logic            dma_wtp_stb,
  output logic            wait_done,
  output logic            spiint_n,
  output logic            tmo_flag,
  output logic [NSRC-1:0] tmo_src
);

  localparam int IDXW = (NSRC > 1) ? $clog2(NSRC) : 1;

  // Handshake: dma_wtp_req is a level held by the DMA engine until it sees the
  // one-cycle dma_wtp_stb; it is only sampled while the FSM sits in S_IDLE.
  typedef enum logic [1:0] {S_IDLE, S_CPU, S_DMA, S_REL} state_t;

  typedef struct packed {
    state_t           state;
    logic [IDXW-1:0]  cur;
    logic [DEVW-1:0]  dev;
    logic             rel_dma;
  } fsm_t;

  fsm_t            fsm;
  logic [NSRC-1:0] prev;
  logic [NSRC-1:0] pend;
  logic [NSRC-1:0] rise;
  logic [NSRC-1:0] cand;
  logic [NSRC-1:0] cand_rest;
  logic [IDXW-1:0] low_idx;
  logic [TMOW-1:0] cnt;
  logic            tmo_hit;

  assign rise      = wait_start & ~prev;
  assign cand      = pend | rise;
  assign cand_rest = cand & ~(NSRC'(1) << low_idx);
  assign tmo_hit   = (tmo_limit != '0) && (cnt == tmo_limit - TMOW'(1));

  // Lowest set bit wins: scan downward so the last hit is the lowest index.
  always_comb begin
    low_idx = '0;
    for (int i = NSRC - 1; i >= 0; i--) begin
      if (cand[i]) low_idx = IDXW'(i);
    end
  end

  assign wait_n          = (fsm.state != S_CPU);
  assign wait_oe         = (fsm.state == S_CPU);
  assign spiint_n        = !((fsm.state == S_CPU) || (fsm.state == S_DMA));
  assign wait_done       = (fsm.state == S_REL);
  assign dma_wtp_stb     = (fsm.state == S_REL) && fsm.rel_dma;
  assign wait_status_wrn = (fsm.state == S_DMA) | wr_n;

  always_comb begin
    wait_status = '0;
    if (fsm.state == S_CPU) wait_status = NSRC'(1) << fsm.cur;
    else if (fsm.state == S_DMA) wait_status = NSRC'(1) << fsm.dev;
  end

  always_ff @(posedge fclk) begin
    prev <= wait_start;
    if (rst) begin
      fsm.state   <= S_IDLE;
      fsm.cur     <= '0;
      fsm.dev     <= '0;
      fsm.rel_dma <= 1'b0;
      pend        <= '0;
      cnt         <= '0;
      tmo_flag    <= 1'b0;
      tmo_src     <= '0;
    end else begin
      if (tmo_clr) tmo_flag <= 1'b0;
      case (fsm.state)
        S_IDLE: begin
          cnt <= '0;
          if (cand != '0) begin
            fsm.state <= S_CPU;
            fsm.cur   <= low_idx;
            pend      <= cand_rest;
          end else if (dma_wtp_req) begin
            fsm.state <= S_DMA;
            fsm.dev   <= dmawpdev;
          end
        end
        S_CPU, S_DMA: begin
          pend <= pend | rise;
          cnt  <= cnt + TMOW'(1);
          if (wait_end) begin
            fsm.state   <= S_REL;
            fsm.rel_dma <= (fsm.state == S_DMA);
          end else if (tmo_hit) begin
            fsm.state   <= S_REL;
            fsm.rel_dma <= (fsm.state == S_DMA);
            tmo_flag    <= 1'b1;
            tmo_src     <= wait_status;
          end
        end
        default: begin
          // Leaving REL: a queued CPU wait starts at once so back-to-back waits
          // are separated by exactly one released cycle; DMA waits for IDLE.
          cnt <= '0;
          if (cand != '0) begin
            fsm.state <= S_CPU;
            fsm.cur   <= low_idx;
            pend      <= cand_rest;
          end else begin
            fsm.state <= S_IDLE;
            pend      <= cand;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_zwait_mc.sv
// Bench for zwait_mc: directed vector table, a long no-timeout hold, and
// randomized traffic checked cycle by cycle against a reference model.
module tb_zwait_mc;
  localparam int NSRC = 4;
  localparam int DEVW = 2;
  localparam int TMOW = 16;
  localparam int OUTW = 15;

  logic            fclk = 1'b0;
  logic            rst;
  logic [NSRC-1:0] wait_start;
  logic            wait_end;
  logic            wr_n;
  logic            dma_wtp_req;
  logic [DEVW-1:0] dmawpdev;
  logic [TMOW-1:0] tmo_limit;
  logic            tmo_clr;
  logic            wait_n;
  logic            wait_oe;
  logic [NSRC-1:0] wait_status;
  logic            wait_status_wrn;
  logic            dma_wtp_stb;
  logic            wait_done;
  logic            spiint_n;
  logic            tmo_flag;
  logic [NSRC-1:0] tmo_src;

  // clock / reset
  always #5 fclk = ~fclk;

  zwait_mc #(.NSRC(NSRC), .DEVW(DEVW), .TMOW(TMOW)) dut (
    .fclk(fclk), .rst(rst), .wait_start(wait_start), .wait_end(wait_end),
    .wr_n(wr_n), .dma_wtp_req(dma_wtp_req), .dmawpdev(dmawpdev),
    .tmo_limit(tmo_limit), .tmo_clr(tmo_clr), .wait_n(wait_n), .wait_oe(wait_oe),
    .wait_status(wait_status), .wait_status_wrn(wait_status_wrn),
    .dma_wtp_stb(dma_wtp_stb), .wait_done(wait_done), .spiint_n(spiint_n),
    .tmo_flag(tmo_flag), .tmo_src(tmo_src)
  );

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  logic [OUTW-1:0] exp_q[$];

  // reference model: phase 0 idle, 1 cpu wait, 2 dma wait, 3 release
  int       m_phase  = 0;
  int       m_act    = 0;
  int       m_el     = 0;
  bit       m_reldma = 0;
  bit       m_pend[NSRC];
  bit       m_prev[NSRC];
  bit       m_flag   = 0;
  logic [NSRC-1:0] m_src = '0;

  task automatic model_tick();
    bit rise[NSRC];
    int low;
    if (rst) begin
      m_phase = 0; m_flag = 0; m_src = '0; m_reldma = 0;
      for (int i = 0; i < NSRC; i++) begin
        m_pend[i] = 0; m_prev[i] = wait_start[i];
      end
      return;
    end
    for (int i = 0; i < NSRC; i++) begin
      rise[i] = wait_start[i] && !m_prev[i];
      m_prev[i] = wait_start[i];
    end
    if (tmo_clr) m_flag = 0;
    if (m_phase == 0 || m_phase == 3) begin
      low = -1;
      for (int i = NSRC - 1; i >= 0; i--) if (m_pend[i] || rise[i]) low = i;
      for (int i = 0; i < NSRC; i++) m_pend[i] = (m_pend[i] || rise[i]) && (i != low);
      if (low >= 0) begin
        m_phase = 1; m_act = low; m_el = 0;
      end else if (m_phase == 0 && dma_wtp_req) begin
        m_phase = 2; m_act = int'(dmawpdev); m_el = 0;
      end else m_phase = 0;
    end else begin
      for (int i = 0; i < NSRC; i++) m_pend[i] = m_pend[i] || rise[i];
      if (wait_end) begin
        m_reldma = (m_phase == 2); m_phase = 3;
      end else if (tmo_limit != 0 && m_el + 1 == int'(tmo_limit)) begin
        m_reldma = (m_phase == 2); m_flag = 1;
        m_src = NSRC'(1) << m_act; m_phase = 3;
      end
      m_el++;
    end
  endtask

  function automatic logic [OUTW-1:0] model_out();
    logic            busy = (m_phase == 1) || (m_phase == 2);
    logic [NSRC-1:0] st   = busy ? (NSRC'(1) << m_act) : '0;
    return {m_phase != 1, m_phase == 1, st, (m_phase == 2) | wr_n,
            (m_phase == 3) && m_reldma, m_phase == 3, !busy, m_flag, m_src};
  endfunction

  function automatic logic [OUTW-1:0] dut_vec();
    return {wait_n, wait_oe, wait_status, wait_status_wrn, dma_wtp_stb,
            wait_done, spiint_n, tmo_flag, tmo_src};
  endfunction

  // driver: one clock with model-scoreboard comparison after the edge
  task automatic step();
    logic [OUTW-1:0] e;
    model_tick();
    exp_q.push_back(model_out());
    @(posedge fclk);
    #1;
    cyc++;
    e = exp_q.pop_front();
    checks++;
    if (dut_vec() !== e) begin
      errors++;
      $display("FAIL model cyc=%0d got=%h exp=%h", cyc, dut_vec(), e);
    end
  endtask

  typedef struct {
    logic            rst;
    logic [NSRC-1:0] ws;
    logic            wend, dreq;
    logic [DEVW-1:0] dev;
    logic            clr;
    logic [TMOW-1:0] lim;
    logic            e_wn;
    logic [NSRC-1:0] e_st;
    logic            e_wrn, e_done, e_stb, e_flag;
    logic [NSRC-1:0] e_src;
  } vec_t;

  vec_t tbl[$];

  function automatic void add(input int r, input int ws, input int we, input int dq,
                              input int dv, input int cl, input int lim, input int wn,
                              input int st, input int wrn, input int dn, input int sb,
                              input int fl, input int src);
    vec_t v;
    v.rst = 1'(r); v.ws = 4'(ws); v.wend = 1'(we); v.dreq = 1'(dq); v.dev = 2'(dv);
    v.clr = 1'(cl); v.lim = 16'(lim); v.e_wn = 1'(wn); v.e_st = 4'(st);
    v.e_wrn = 1'(wrn); v.e_done = 1'(dn); v.e_stb = 1'(sb); v.e_flag = 1'(fl);
    v.e_src = 4'(src);
    tbl.push_back(v);
  endfunction

  initial begin
    logic [OUTW-1:0] e;
    rst = 1'b1; wait_start = '0; wait_end = 0; wr_n = 0; dma_wtp_req = 0;
    dmawpdev = '0; tmo_limit = '0; tmo_clr = 0;

    // single CPU wait on bit 2, released by wait_end
    add(1, 0, 0, 0, 0, 0, 0,  1, 0, 0, 0, 0, 0, 0);
    add(0, 4, 0, 0, 0, 0, 0,  0, 4, 0, 0, 0, 0, 0);
    repeat (4) add(0, 4, 0, 0, 0, 0, 0,  0, 4, 0, 0, 0, 0, 0);
    add(0, 4, 1, 0, 0, 0, 0,  1, 0, 0, 1, 0, 0, 0);
    add(0, 4, 0, 0, 0, 0, 0,  1, 0, 0, 0, 0, 0, 0);
    add(0, 0, 0, 0, 0, 0, 0,  1, 0, 0, 0, 0, 0, 0);
    // simultaneous rises on bits 1 and 3
    add(0, 10, 0, 0, 0, 0, 0,  0, 2, 0, 0, 0, 0, 0);
    add(0, 10, 1, 0, 0, 0, 0,  1, 0, 0, 1, 0, 0, 0);
    add(0, 10, 0, 0, 0, 0, 0,  0, 8, 0, 0, 0, 0, 0);
    add(0, 0, 1, 0, 0, 0, 0,   1, 0, 0, 1, 0, 0, 0);
    add(0, 0, 0, 0, 0, 0, 0,   1, 0, 0, 0, 0, 0, 0);
    // DMA wait on device 2 with a CPU rise queued behind it
    add(0, 0, 0, 1, 2, 0, 0,  1, 4, 1, 0, 0, 0, 0);
    add(0, 1, 0, 1, 0, 0, 0,  1, 4, 1, 0, 0, 0, 0);
    add(0, 1, 1, 1, 0, 0, 0,  1, 0, 0, 1, 1, 0, 0);
    add(0, 1, 0, 0, 0, 0, 0,  0, 1, 0, 0, 0, 0, 0);
    add(0, 1, 1, 0, 0, 0, 0,  1, 0, 0, 1, 0, 0, 0);
    add(0, 0, 0, 0, 0, 0, 0,  1, 0, 0, 0, 0, 0, 0);
    // timeout at limit 10, then clear
    add(0, 1, 0, 0, 0, 0, 10,  0, 1, 0, 0, 0, 0, 0);
    repeat (9) add(0, 1, 0, 0, 0, 0, 10,  0, 1, 0, 0, 0, 0, 0);
    add(0, 1, 0, 0, 0, 0, 10,  1, 0, 0, 1, 0, 1, 1);
    add(0, 1, 0, 0, 0, 0, 10,  1, 0, 0, 0, 0, 1, 1);
    add(0, 0, 0, 0, 0, 1, 10,  1, 0, 0, 0, 0, 0, 1);
    // wait_end coinciding with the timeout is a normal release
    add(0, 2, 0, 0, 0, 0, 10,  0, 2, 0, 0, 0, 0, 1);
    repeat (9) add(0, 2, 0, 0, 0, 0, 10,  0, 2, 0, 0, 0, 0, 1);
    add(0, 2, 1, 0, 0, 0, 10,  1, 0, 0, 1, 0, 0, 1);
    add(0, 2, 0, 0, 0, 0, 10,  1, 0, 0, 0, 0, 0, 1);
    // timeout and tmo_clr together: set wins
    add(0, 6, 0, 0, 0, 0, 3,  0, 4, 0, 0, 0, 0, 1);
    repeat (2) add(0, 6, 0, 0, 0, 0, 3,  0, 4, 0, 0, 0, 0, 1);
    add(0, 6, 0, 0, 0, 1, 3,  1, 0, 0, 1, 0, 1, 4);
    add(0, 0, 0, 0, 0, 1, 3,  1, 0, 0, 0, 0, 0, 4);
    // input high through reset, then reset in mid-wait
    add(1, 1, 0, 0, 0, 0, 0,  1, 0, 0, 0, 0, 0, 0);
    add(0, 1, 0, 0, 0, 0, 0,  1, 0, 0, 0, 0, 0, 0);
    add(0, 3, 0, 0, 0, 0, 0,  0, 2, 0, 0, 0, 0, 0);
    add(0, 7, 0, 0, 0, 0, 0,  0, 2, 0, 0, 0, 0, 0);
    add(1, 7, 0, 0, 0, 0, 0,  1, 0, 0, 0, 0, 0, 0);
    add(0, 7, 0, 0, 0, 0, 0,  1, 0, 0, 0, 0, 0, 0);
    add(0, 0, 0, 0, 0, 0, 0,  1, 0, 0, 0, 0, 0, 0);

    foreach (tbl[k]) begin
      rst = tbl[k].rst; wait_start = tbl[k].ws; wait_end = tbl[k].wend;
      dma_wtp_req = tbl[k].dreq; dmawpdev = tbl[k].dev; tmo_clr = tbl[k].clr;
      tmo_limit = tbl[k].lim;
      step();
      e = {tbl[k].e_wn, ~tbl[k].e_wn, tbl[k].e_st, tbl[k].e_wrn, tbl[k].e_stb,
           tbl[k].e_done, (tbl[k].e_st == 4'h0), tbl[k].e_flag, tbl[k].e_src};
      checks++;
      if (dut_vec() !== e) begin
        errors++;
        $display("FAIL tbl[%0d] got=%h exp=%h", k, dut_vec(), e);
      end
    end

    // timeout disabled: a very long wait is not released
    rst = 0; wait_end = 0; tmo_clr = 0; tmo_limit = '0; wait_start = 4'b1000;
    repeat (70000) step();
    checks++;
    if (wait_n !== 1'b0 || wait_status !== 4'b1000) begin
      errors++;
      $display("FAIL long_hold wait_n=%b status=%b exp 0/1000", wait_n, wait_status);
    end
    wait_end = 1;
    step();
    checks++;
    if (wait_done !== 1'b1 || tmo_flag !== 1'b0 || wait_n !== 1'b1) begin
      errors++;
      $display("FAIL long_release done=%b flag=%b wait_n=%b exp 1/0/1",
               wait_done, tmo_flag, wait_n);
    end
    wait_end = 0; wait_start = '0;
    step();

    // randomized traffic against the model
    for (int c = 0; c < 3000; c++) begin
      if (c % 200 == 0)
        tmo_limit = ($urandom_range(0, 3) == 0) ? 16'd0 : 16'($urandom_range(1, 12));
      rst = ($urandom_range(0, 499) == 0);
      for (int b = 0; b < NSRC; b++)
        if ($urandom_range(0, 5) == 0) wait_start[b] = ~wait_start[b];
      wait_end = ($urandom_range(0, 5) == 0);
      tmo_clr  = ($urandom_range(0, 19) == 0);
      wr_n     = 1'($urandom_range(0, 1));
      dmawpdev = 2'($urandom_range(0, 3));
      if (!dma_wtp_req && $urandom_range(0, 9) == 0) dma_wtp_req = 1;
      step();
      if (dma_wtp_stb) dma_wtp_req = 0;
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
